seg7_scan_driver: RTL and testbench

Time-multiplexed driver for an 8-digit common-anode 7-segment display, sitting directly downstream of the memory-mapped print controller. It consumes the eight active-low segment patterns that the controller's hex decoders produce, and drives one shared active-low segment bus plus eight active-low digit enables. Segment data is snapshotted once per frame, so a CPU store landing mid-scan never shows as a torn display. The block also provides dead-time blanking between digits, 16-level brightness, and a per-digit enable mask.

---
 rtl/seg7_scan_driver_if.sv | 29 ++
 rtl/seg7_scan_driver.sv | 101 ++++++++++
 tb/tb_seg7_scan_driver.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_if: signal bundle between the print controller side and the
// 8-digit 7-segment scan driver.
//   en           scan enable
//   seg_in[d]    active-low segment pattern for digit d
//   digit_mask   1 = digit d may light
//   brightness   0 = dark, 15 = full on-time
//   seg_out      active-low shared segment bus
//   an_out       active-low digit enables, at most one bit low
//   frame_strobe one-cycle pulse when a new snapshot is taken
// master = controller/stimulus side, slave = scan driver.
interface seg7_scan_if;
  logic       en;
  logic [6:0] seg_in [8];
  logic [7:0] digit_mask;
  logic [3:0] brightness;
  logic [6:0] seg_out;
  logic [7:0] an_out;
  logic       frame_strobe;

  modport master (
    output en, seg_in, digit_mask, brightness,
    input  seg_out, an_out, frame_strobe
  );

  modport slave (
    input  en, seg_in, digit_mask, brightness,
    output seg_out, an_out, frame_strobe
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an 8-digit common-anode
// 7-segment display. Each digit owns a slot of CLK_DIV cycles; the first
// BLANK_CYCLES of a slot keep all anodes off, then the digit is lit for an
// on-time scaled by a 4-bit brightness. Segment data is snapshotted once per
// frame so a mid-scan update never tears the display.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    seg7_scan_if.slave (en, seg_in, digit_mask, brightness in;
//          seg_out, an_out, frame_strobe out, all registered)
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_DIV      = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  seg7_scan_if.slave   bus
);

  localparam int DW     = $clog2(NUM_DIGITS);
  localparam int ACTIVE = CLK_DIV - BLANK_CYCLES;

  logic [15:0]   cnt;
  logic [DW-1:0] digit;
  logic [3:0]    bright_q;
  logic [6:0]    snap [NUM_DIGITS];

  logic          slot_end;
  logic          frame_end;
  logic [19:0]   on_len;
  logic [19:0]   cnt_w;
  logic          lit;
  logic [7:0]    an_next;

  assign slot_end  = (cnt == 16'(CLK_DIV - 1));
  assign frame_end = slot_end && (digit == DW'(NUM_DIGITS - 1));

  // Full 20-bit product before the shift so brightness 15 yields exactly ACTIVE.
  assign on_len = (20'(ACTIVE) * (20'(bright_q) + 20'd1)) >> 4;
  assign cnt_w  = {4'd0, cnt};

  assign lit = bus.en && bus.digit_mask[digit]
            && (cnt_w >= 20'(BLANK_CYCLES))
            && (cnt_w <  20'(BLANK_CYCLES) + on_len);

  // Slot counter, digit pointer and brightness latch. Brightness is only
  // sampled at a slot boundary so the current slot's on-time never changes.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      digit    <= '0;
      bright_q <= '0;
    end else if (!bus.en) begin
      cnt      <= '0;
      digit    <= '0;
      bright_q <= bus.brightness;
    end else if (slot_end) begin
      cnt      <= '0;
      digit    <= digit + DW'(1);
      bright_q <= bus.brightness;
    end else begin
      cnt      <= cnt + 16'd1;
    end
  end

  // Frame snapshot: tracks seg_in while idle, otherwise reloads only at the
  // very last cycle of the frame.
  // NOTE: the snapshot is a small register array, not a RAM, so it gets a
  // reset value; blank (7'h7F) keeps the first frame dark until data arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < NUM_DIGITS; d++) snap[d] <= 7'h7F;
    end else if (!bus.en || frame_end) begin
      for (int d = 0; d < NUM_DIGITS; d++) snap[d] <= bus.seg_in[d];
    end
  end

  // One-cold anode pattern for the current digit when lit.
  // NOTE: default assigned first so no path leaves an_next unassigned (no latch).
  always_comb begin
    an_next = 8'hFF;
    if (lit) an_next[digit] = 1'b0;
  end

  // Registered outputs: one cycle of latency from cnt/digit/snap/en state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an_out       <= 8'hFF;
      bus.seg_out      <= 7'h7F;
      bus.frame_strobe <= 1'b0;
    end else begin
      bus.an_out       <= an_next;
      bus.seg_out      <= snap[digit];
      bus.frame_strobe <= bus.en && frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (CLK_DIV=16, BLANK_CYCLES=2).
// A cycle model pushes the expected registered outputs into a queue at each
// clock edge; an independent monitor pops and compares just after the edge.
// Directed per-frame checks (lit cycles per digit, segment values), strobe
// spacing, one-cold anodes and dead-time gaps are checked alongside.
module tb_seg7_scan_driver;

  localparam int CLK_DIV = 16;
  localparam int BLANK   = 2;
  localparam int ACTIVE  = CLK_DIV - BLANK;
  localparam int FRAME   = 8 * CLK_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_if bus ();

  seg7_scan_driver #(
    .NUM_DIGITS  (8),
    .CLK_DIV     (CLK_DIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       fs;
  } obs_t;

  typedef int         lit_t  [8];
  typedef logic [6:0] segv_t [8];

  obs_t exp_q [$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- cycle model (scoreboard producer) ----------------
  int         m_cnt;
  int         m_digit;
  logic [3:0] m_bq;
  logic [6:0] m_snap [8];
  int         m_on_len;
  obs_t       m_e;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt   = 0;
        m_digit = 0;
        m_bq    = 4'd0;
        for (int d = 0; d < 8; d++) m_snap[d] = 7'h7F;
        exp_q.delete();
      end else begin
        m_on_len = (ACTIVE * (int'(m_bq) + 1)) / 16;
        m_e.an   = 8'hFF;
        if (bus.en && bus.digit_mask[m_digit] && m_cnt >= BLANK && m_cnt < BLANK + m_on_len)
          m_e.an[m_digit] = 1'b0;
        m_e.seg = m_snap[m_digit];
        m_e.fs  = bus.en && (m_digit == 7) && (m_cnt == CLK_DIV - 1);
        exp_q.push_back(m_e);
        if (!bus.en) begin
          m_cnt   = 0;
          m_digit = 0;
          m_bq    = bus.brightness;
          for (int d = 0; d < 8; d++) m_snap[d] = bus.seg_in[d];
        end else begin
          if (m_digit == 7 && m_cnt == CLK_DIV - 1)
            for (int d = 0; d < 8; d++) m_snap[d] = bus.seg_in[d];
          if (m_cnt == CLK_DIV - 1) begin
            m_cnt   = 0;
            m_digit = (m_digit + 1) % 8;
            m_bq    = bus.brightness;
          end else begin
            m_cnt++;
          end
        end
      end
    end
  end

  // ---------------- monitor (scoreboard consumer) ----------------
  obs_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("an_out",       bus.an_out,       mon_e.an);
        check("seg_out",      bus.seg_out,      mon_e.seg);
        check("frame_strobe", bus.frame_strobe, mon_e.fs);
      end
    end
  end

  // ---------------- property watchers ----------------
  int pos_cnt = 0;
  initial forever begin
    @(posedge clk);
    pos_cnt++;
  end

  int strobe_last  = 0;
  bit strobe_valid = 1'b0;
  int ff_run       = 0;
  int last_d       = 0;
  bit last_valid   = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !bus.en) begin
        strobe_valid = 1'b0;
      end
      if (rst_n) begin
        if (bus.frame_strobe) begin
          if (strobe_valid) check("strobe_period", pos_cnt - strobe_last, FRAME);
          strobe_last  = pos_cnt;
          strobe_valid = bus.en;
        end
        check("an_one_cold", ($countones(~bus.an_out) <= 1), 1);
        if (bus.an_out == 8'hFF) begin
          ff_run++;
        end else begin
          for (int d = 0; d < 8; d++) begin
            if (!bus.an_out[d]) begin
              if (last_valid && d != last_d) check("dead_time_gap", (ff_run >= BLANK), 1);
              last_d = d;
            end
          end
          last_valid = 1'b1;
          ff_run     = 0;
        end
      end else begin
        last_valid = 1'b0;
        ff_run     = 0;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  int    base = 0;
  lit_t  lit;
  segv_t segv;

  // Return at the falling edge just before the k-th rising edge since base.
  task automatic goto(input int k);
    while (pos_cnt - base < k) @(negedge clk);
  endtask

  task automatic collect_frame(output lit_t l, output segv_t s);
    for (int d = 0; d < 8; d++) begin
      l[d] = 0;
      s[d] = 7'h7F;
    end
    repeat (FRAME) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 8; d++) begin
        if (!bus.an_out[d]) begin
          l[d]++;
          s[d] = bus.seg_out;
        end
      end
    end
  endtask

  task automatic check_frame(input string tag, input lit_t l, input segv_t s,
                             input lit_t req_l, input segv_t req_s);
    for (int d = 0; d < 8; d++) begin
      check($sformatf("%s_lit_d%0d", tag, d), l[d], req_l[d]);
      if (req_l[d] != 0) check($sformatf("%s_seg_d%0d", tag, d), s[d], req_s[d]);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.en         = 1'b0;
    bus.digit_mask = 8'hFF;
    bus.brightness = 4'd15;
    for (int d = 0; d < 8; d++) bus.seg_in[d] = 7'(d + 1);

    // Reset values while rst_n is held low.
    repeat (3) @(negedge clk);
    check("rst_an_out",       bus.an_out,       8'hFF);
    check("rst_seg_out",      bus.seg_out,      7'h7F);
    check("rst_frame_strobe", bus.frame_strobe, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Raise en and change seg_in in the same cycle: frame A must still show
    // the d+1 patterns captured while en was low.
    bus.en = 1'b1;
    for (int d = 0; d < 8; d++) bus.seg_in[d] = 7'h55;
    bus.seg_in[3] = 7'h40;
    base = pos_cnt;
    @(posedge clk);

    collect_frame(lit, segv);
    check_frame("basic", lit, segv, '{14, 14, 14, 14, 14, 14, 14, 14},
                '{7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h08});

    // Frame B: seg_in[3] changes during digit 1, brightness changes at
    // digit 2 / cnt 5 (slot 2 keeps 14 cycles, later slots drop to 7).
    fork
      collect_frame(lit, segv);
      begin
        goto(FRAME + 1 * CLK_DIV + 4);
        bus.seg_in[3] = 7'h79;
        goto(FRAME + 2 * CLK_DIV + 5);
        bus.brightness = 4'd7;
      end
    join
    check_frame("bright_mid", lit, segv, '{14, 14, 14, 7, 7, 7, 7, 7},
                '{7'h55, 7'h55, 7'h55, 7'h40, 7'h55, 7'h55, 7'h55, 7'h55});

    // Frame C: new snapshot shows 7'h79 in slot 3; brightness 0 requested late.
    fork
      collect_frame(lit, segv);
      begin
        goto(2 * FRAME + 7 * CLK_DIV + 10);
        bus.brightness = 4'd0;
      end
    join
    check_frame("snapshot", lit, segv, '{7, 7, 7, 7, 7, 7, 7, 7},
                '{7'h55, 7'h55, 7'h55, 7'h79, 7'h55, 7'h55, 7'h55, 7'h55});

    // Frame D: dark; full brightness and odd-digit mask requested late.
    fork
      collect_frame(lit, segv);
      begin
        goto(3 * FRAME + 7 * CLK_DIV + 3);
        bus.brightness = 4'd15;
        bus.digit_mask = 8'b1010_1010;
      end
    join
    check_frame("dark", lit, segv, '{0, 0, 0, 0, 0, 0, 0, 0},
                '{7'h55, 7'h55, 7'h55, 7'h79, 7'h55, 7'h55, 7'h55, 7'h55});

    // Frame E: only odd digits light, each with full slot timing.
    collect_frame(lit, segv);
    check_frame("mask", lit, segv, '{0, 14, 0, 14, 0, 14, 0, 14},
                '{7'h55, 7'h55, 7'h55, 7'h79, 7'h55, 7'h55, 7'h55, 7'h55});

    // Drop en at digit 5, cnt 9.
    goto(5 * FRAME + 5 * CLK_DIV + 9);
    check("en_drop_before", bus.an_out, 8'hDF);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check("en_drop_after", bus.an_out, 8'hFF);

    // Re-enable: digit 0 lights at cnt 2 plus one cycle of latency.
    @(negedge clk);
    bus.digit_mask = 8'hFF;
    repeat (4) @(negedge clk);
    bus.en = 1'b1;
    base   = pos_cnt;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("reenable_cnt1", bus.an_out, 8'hFF);
    @(posedge clk);
    #1;
    check("reenable_cnt2", bus.an_out, 8'hFE);
    check("reenable_seg",  bus.seg_out, 7'h55);

    // Asynchronous reset mid-slot.
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_an",  bus.an_out,       8'hFF);
    check("async_rst_seg", bus.seg_out,      7'h7F);
    check("async_rst_fs",  bus.frame_strobe, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Random brightness / mask / data over about ten frames.
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(10, 22)) @(negedge clk);
      bus.brightness = 4'($urandom);
      bus.digit_mask = 8'($urandom);
      if (i % 8 == 0)
        for (int d = 0; d < 8; d++) bus.seg_in[d] = 7'($urandom);
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
